pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter HANDLER_ADDR, default 32'h00000020, exception vector for all non-ERET exceptions.
REQ-002 The block SHALL have parameter REFILL_CYCLES, default 2, range 1..15, length of post-flush refill window.
REQ-003 The block SHALL have parameter WDT_LIMIT, default 255, range 1..65535, consecutive-stall threshold (used only under STALL_WDT_EN).
REQ-004 The block SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have ports stallreq_if / stallreq_id / stallreq_ex / stallreq_mem  input  1 each  stall requests from fetch wait, load-use, multi-cycle EX, data-bus wait.
REQ-007 The block SHALL have port except_type_i  input  32  MEM-stage exception code, 0 = none.
REQ-008 The block SHALL have port cp0_epc_i  input  32  current CP0 EPC register value.
REQ-009 The block SHALL have ports wb_cp0_wena  input  1, wb_cp0_waddr  input  5, wb_cp0_wdata  input  32  WB-stage CP0 write, for EPC forwarding.
REQ-010 The block SHALL have port stall  output  6  per-stage hold: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; stage register k/k+1 uses stall[k+1:k].
REQ-011 The block SHALL have port flush  output  1  clears all pipeline registers this cycle.
REQ-012 The block SHALL have port new_pc  output  32  redirect target, valid only while flush=1, else 0.
REQ-013 The block SHALL have port in_refill  output  1  high while FSM is in REFILL.
REQ-014 The block SHALL have port wdt_err  output  1  sticky stall-watchdog error (0 when STALL_WDT_EN is undefined).

Function
REQ-015 The FSM SHALL have states RUN and REFILL, plus a 4-bit refill counter.
REQ-016 In RUN, stall SHALL be combinational, highest stage wins: mem -> 6'b011111; ex -> 6'b001111; id -> 6'b000111; if -> 6'b000011; none -> 6'b000000.
REQ-017 An exception SHALL be taken in the same cycle when except_type_i != 0 and stallreq_mem = 0; flush=1, stall=0, and the FSM goes to REFILL with counter = REFILL_CYCLES-1.
REQ-018 If except_type_i != 0 while stallreq_mem = 1, flush SHALL stay 0 and the MEM stall SHALL apply; the exception is taken in the first cycle stallreq_mem drops.
REQ-019 new_pc SHALL be the EPC when except_type_i = 32'h0000000e (ERET), else HANDLER_ADDR.
REQ-020 EPC SHALL be wb_cp0_wdata when wb_cp0_wena=1 and wb_cp0_waddr=14 in the same cycle, else cp0_epc_i.
REQ-021 In REFILL, stallreq_id, stallreq_ex and except_type_i SHALL be ignored; stallreq_mem and stallreq_if SHALL be honoured per REQ-016.
REQ-022 In REFILL, the counter SHALL decrement each cycle; at 0 the FSM SHALL return to RUN next cycle.
REQ-023 flush SHALL be high for exactly one cycle per exception and SHALL never coincide with a nonzero stall.
REQ-024 All outputs SHALL be pure functions of state and current inputs, with no input-to-output registering; latency from request to stall SHALL be 0 cycles.

Reset
REQ-025 While rst=0 at a clock edge, state SHALL become RUN, counter 0, watchdog counter 0, wdt_err 0.
REQ-026 While rst=0, stall=0, flush=0, new_pc=0 and in_refill=0 SHALL hold regardless of inputs; reset mid-REFILL SHALL abort REFILL.

Configuration
REQ-027 With macro STALL_WDT_EN defined, a 16-bit counter SHALL increment on each cycle with stall != 0, clear on a cycle with stall = 0 or flush=1, saturate at WDT_LIMIT, and set wdt_err when it reaches WDT_LIMIT; wdt_err SHALL clear only on reset.
REQ-028 Without STALL_WDT_EN, the counter SHALL be absent and wdt_err SHALL be tied to 0.

Verification
REQ-029 stallreq_ex=1 and stallreq_if=1 in RUN -> stall=6'b001111, flush=0.
REQ-030 except_type_i=32'h00000008, no stalls -> flush=1, new_pc=32'h00000020, in_refill=1 for the next 2 cycles, then RUN.
REQ-031 ERET (32'h0000000e), cp0_epc_i=32'h00001000, WB writes EPC=32'h00002000 in the same cycle -> new_pc=32'h00002000.
REQ-032 Exception with stallreq_mem=1 for 3 cycles -> stall=6'b011111 and flush=0 for 3 cycles, flush=1 on the 4th.
REQ-033 stallreq_id=1 during REFILL -> stall=0; rst=0 during REFILL -> RUN, all outputs 0.
REQ-034 STALL_WDT_EN, WDT_LIMIT=4, stallreq_mem held 4 cycles -> wdt_err=1 from the 5th edge, held after stalls release.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: stall vector, flush, redirect PC and post-flush refill window.
// Optional stall watchdog is built only when STALL_WDT_EN is defined.
//
// state  | meaning
// RUN    | normal operation, stalls and exceptions honoured
// REFILL | post-flush window, only IF/MEM stalls honoured
module pipe_ctrl #(
    parameter logic [31:0] HANDLER_ADDR  = 32'h00000020,
    parameter int          REFILL_CYCLES = 2,
    parameter int          WDT_LIMIT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] except_type_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_wena,
    input  logic [4:0]  wb_cp0_waddr,
    input  logic [31:0] wb_cp0_wdata,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        in_refill,
    output logic        wdt_err
);

    localparam logic [31:0] ERET_CODE = 32'h0000000e;
    localparam logic [4:0]  EPC_ADDR  = 5'd14;

    if (REFILL_CYCLES < 1 || REFILL_CYCLES > 15) begin : g_bad_refill
        $error("pipe_ctrl: REFILL_CYCLES out of range 1..15");
    end
    if (WDT_LIMIT < 1 || WDT_LIMIT > 65535) begin : g_bad_wdt
        $error("pipe_ctrl: WDT_LIMIT out of range 1..65535");
    end

    typedef enum logic {
        RUN    = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [31:0] epc;

    // The WB stage may be writing EPC this very cycle; ERET must see that value.
    assign epc = (wb_cp0_wena && wb_cp0_waddr == EPC_ADDR) ? wb_cp0_wdata : cp0_epc_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 6'b000000;
        flush      = 1'b0;
        new_pc     = 32'h0;
        in_refill  = 1'b0;
        if (rst) begin
            case (state)
                RUN: begin
                    if (except_type_i != 32'h0 && !stallreq_mem) begin
                        flush      = 1'b1;
                        new_pc     = (except_type_i == ERET_CODE) ? epc : HANDLER_ADDR;
                        state_next = REFILL;
                        cnt_next   = 4'(REFILL_CYCLES - 1);
                    end else if (stallreq_mem) begin
                        stall = 6'b011111;
                    end else if (stallreq_ex) begin
                        stall = 6'b001111;
                    end else if (stallreq_id) begin
                        stall = 6'b000111;
                    end else if (stallreq_if) begin
                        stall = 6'b000011;
                    end
                end
                REFILL: begin
                    in_refill = 1'b1;
                    if (stallreq_mem) begin
                        stall = 6'b011111;
                    end else if (stallreq_if) begin
                        stall = 6'b000011;
                    end
                    if (cnt == 4'd0) begin
                        state_next = RUN;
                    end else begin
                        cnt_next = cnt - 4'd1;
                    end
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

`ifdef STALL_WDT_EN
    logic [15:0] wdt_cnt;
    logic        wdt_flag;

    // Error latches one edge after the counter saturates; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wdt_cnt  <= 16'd0;
            wdt_flag <= 1'b0;
        end else begin
            if (wdt_cnt == 16'(WDT_LIMIT)) begin
                wdt_flag <= 1'b1;
            end
            if (flush || stall == 6'b000000) begin
                wdt_cnt <= 16'd0;
            end else if (wdt_cnt != 16'(WDT_LIMIT)) begin
                wdt_cnt <= wdt_cnt + 16'd1;
            end
        end
    end

    assign wdt_err = wdt_flag;
`else
    assign wdt_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, exception/ERET redirect, refill window, reset abort.
// The watchdog section is compiled only when STALL_WDT_EN is defined.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] except_type_i, cp0_epc_i, wb_cp0_wdata;
    logic        wb_cp0_wena;
    logic [4:0]  wb_cp0_waddr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        in_refill;
    logic        wdt_err;

    int total = 0;
    int bad   = 0;

    pipe_ctrl #(
        .HANDLER_ADDR (32'h00000020),
        .REFILL_CYCLES(2),
        .WDT_LIMIT    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .except_type_i(except_type_i),
        .cp0_epc_i    (cp0_epc_i),
        .wb_cp0_wena  (wb_cp0_wena),
        .wb_cp0_waddr (wb_cp0_waddr),
        .wb_cp0_wdata (wb_cp0_wdata),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .in_refill    (in_refill),
        .wdt_err      (wdt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        stallreq_if   = 1'b0;
        stallreq_id   = 1'b0;
        stallreq_ex   = 1'b0;
        stallreq_mem  = 1'b0;
        except_type_i = 32'h0;
        cp0_epc_i     = 32'h0;
        wb_cp0_wena   = 1'b0;
        wb_cp0_waddr  = 5'd0;
        wb_cp0_wdata  = 32'h0;
    endtask

    task automatic set_req(input logic [3:0] r);
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = r;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{4'b0000, 6'b000000};
        vecs[1] = '{4'b0001, 6'b000011};
        vecs[2] = '{4'b0010, 6'b000111};
        vecs[3] = '{4'b0011, 6'b000111};
        vecs[4] = '{4'b0101, 6'b001111};
        vecs[5] = '{4'b1000, 6'b011111};
        vecs[6] = '{4'b1111, 6'b011111};

        clr_in();
        rst = 1'b0;
        stallreq_mem  = 1'b1;
        except_type_i = 32'h8;
        tick();
        tick();
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_newpc", new_pc, 32'h0);
        chk("rst_refill", 32'(in_refill), 32'h0);
        chk("rst_wdt", 32'(wdt_err), 32'h0);

        clr_in();
        rst = 1'b1;
        tick();
        foreach (vecs[i]) begin
            set_req(vecs[i].req);
            #1;
            chk($sformatf("prio_%0d", i), 32'(stall), 32'(vecs[i].exp));
            chk($sformatf("prio_flush_%0d", i), 32'(flush), 32'h0);
        end
        clr_in();

        // Plain exception, two-cycle refill window
        tick();
        except_type_i = 32'h8;
        #1;
        chk("exc_flush", 32'(flush), 32'h1);
        chk("exc_newpc", new_pc, 32'h20);
        chk("exc_stall", 32'(stall), 32'h0);
        chk("exc_refill0", 32'(in_refill), 32'h0);
        tick();
        except_type_i = 32'h0;
        #1;
        chk("refill_1", 32'(in_refill), 32'h1);
        chk("refill_1_flush", 32'(flush), 32'h0);
        tick();
        chk("refill_2", 32'(in_refill), 32'h1);
        tick();
        chk("refill_done", 32'(in_refill), 32'h0);

        // ERET with EPC forwarded from WB, then a non-EPC write
        except_type_i = 32'h0000000e;
        cp0_epc_i     = 32'h00001000;
        wb_cp0_wena   = 1'b1;
        wb_cp0_waddr  = 5'd14;
        wb_cp0_wdata  = 32'h00002000;
        #1;
        chk("eret_fwd", new_pc, 32'h00002000);
        wb_cp0_waddr = 5'd13;
        #1;
        chk("eret_nofwd", new_pc, 32'h00001000);
        chk("eret_flush", 32'(flush), 32'h1);
        tick();
        clr_in();
        stallreq_id   = 1'b1;
        stallreq_ex   = 1'b1;
        except_type_i = 32'h8;
        #1;
        chk("refill_ign_stall", 32'(stall), 32'h0);
        chk("refill_ign_flush", 32'(flush), 32'h0);
        stallreq_if = 1'b1;
        #1;
        chk("refill_if", 32'(stall), 32'h3);
        tick();
        stallreq_mem = 1'b1;
        #1;
        chk("refill_mem", 32'(stall), 32'h1f);
        chk("refill_mem_flag", 32'(in_refill), 32'h1);
        tick();
        clr_in();
        #1;
        chk("back_run", 32'(in_refill), 32'h0);

        // Exception held off by MEM stall for three cycles
        except_type_i = 32'h8;
        stallreq_mem  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("hold_stall_%0d", c), 32'(stall), 32'h1f);
            chk($sformatf("hold_flush_%0d", c), 32'(flush), 32'h0);
            tick();
        end
        stallreq_mem = 1'b0;
        #1;
        chk("hold_taken", 32'(flush), 32'h1);
        chk("hold_taken_stall", 32'(stall), 32'h0);
        tick();
        except_type_i = 32'h0;
        #1;
        chk("abort_pre", 32'(in_refill), 32'h1);

        // Reset mid-refill aborts the window
        rst         = 1'b0;
        stallreq_if = 1'b1;
        #1;
        chk("abort_stall", 32'(stall), 32'h0);
        chk("abort_refill", 32'(in_refill), 32'h0);
        tick();
        rst = 1'b1;
        clr_in();
        stallreq_id = 1'b1;
        #1;
        chk("abort_run", 32'(in_refill), 32'h0);
        chk("abort_run_stall", 32'(stall), 32'h7);
        clr_in();

`ifdef STALL_WDT_EN
        rst = 1'b0;
        tick();
        rst = 1'b1;
        stallreq_mem = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
        end
        stallreq_mem = 1'b0;
        #1;
        chk("wdt_before", 32'(wdt_err), 32'h0);
        tick();
        chk("wdt_set", 32'(wdt_err), 32'h1);
        tick();
        tick();
        chk("wdt_sticky", 32'(wdt_err), 32'h1);
`else
        tick();
        chk("wdt_tied", 32'(wdt_err), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
